// File: rtl/mem_port_arbiter_if.sv
// Bundles the I-cache, D-cache and downstream memory port signals of the arbiter.
// slave is the arbiter's view; master is the view of the caches plus memory around it.
interface mem_port_arbiter_if #(
  parameter int LINE_W = 128,
  parameter int ADR_W  = 12
);
  logic              i_read;
  logic [ADR_W-1:0]  i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADR_W-1:0]  d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADR_W-1:0]  mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-side and D-side miss paths.
// state   | meaning
// IDLE    | sample requests, grant one, register the downstream command
// SERVE_I | I-cache read outstanding downstream
// SERVE_D | D-cache read or writeback outstanding downstream
// DONE    | resp pulse cycle; requests ignored so the winner can drop its request
module mem_port_arbiter #(
  parameter int LINE_W = 128,
  parameter int ADR_W  = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t state;
  logic   last_grant_d;
  logic   i_req;
  logic   d_req;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant_d    <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_address <= {ADR_W{1'b0}};
      bus.mem_wdata   <= {LINE_W{1'b0}};
      bus.i_rdata     <= {LINE_W{1'b0}};
      bus.d_rdata     <= {LINE_W{1'b0}};
      bus.i_resp      <= 1'b0;
      bus.d_resp      <= 1'b0;
    end else begin
      bus.i_resp <= 1'b0;
      bus.d_resp <= 1'b0;
      unique case (state)
        IDLE: begin
          // On a tie the requester that did not win last time gets the port.
          if (i_req && (!d_req || last_grant_d)) begin
            bus.mem_address <= bus.i_address;
            bus.mem_read    <= 1'b1;
            bus.mem_write   <= 1'b0;
            last_grant_d    <= 1'b0;
            state           <= SERVE_I;
          end else if (d_req) begin
            bus.mem_address <= bus.d_address;
            bus.mem_wdata   <= bus.d_wdata;
            bus.mem_write   <= bus.d_write;
            bus.mem_read    <= ~bus.d_write;
            last_grant_d    <= 1'b1;
            state           <= SERVE_D;
          end
        end
        SERVE_I: begin
          if (bus.mem_resp) begin
            bus.mem_read <= 1'b0;
            bus.i_rdata  <= bus.mem_rdata;
            bus.i_resp   <= 1'b1;
            state        <= DONE;
          end
        end
        SERVE_D: begin
          if (bus.mem_resp) begin
            // mem_write still holds the registered command type here.
            if (!bus.mem_write) bus.d_rdata <= bus.mem_rdata;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.d_resp    <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model (alternating tie-break, per-requester line copies).
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passes = 0;

  // model state: who won the last grant (0 = I, 1 = D) and each requester's last returned line
  int last_g = 0;
  logic [127:0] i_exp = '0;
  logic [127:0] d_exp = '0;

  mem_port_arbiter_if #(.LINE_W(128), .ADR_W(12)) bus ();
  mem_port_arbiter #(.LINE_W(128), .ADR_W(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic apply_reset();
    bus.i_read = 0; bus.i_address = '0; bus.d_read = 0; bus.d_write = 0;
    bus.d_address = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_resp = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    last_g = 0; i_exp = '0; d_exp = '0;
  endtask

  // Runs one round: the chosen requesters assert, each is held until its resp.
  // The bench memory answers each command after `delay` cycles.
  task automatic do_round(input bit want_i, input bit want_d, input bit d_rd, input bit d_wr,
                          input logic [11:0] ia, input logic [11:0] da, input logic [127:0] wd,
                          input int delay);
    int order[$];
    bit pend_i, pend_d, prev_cmd, cmd;
    int wait_cnt, cyc, cur;
    logic [127:0] fired;
    if (want_i && want_d) begin
      if (last_g == 1) begin order.push_back(0); order.push_back(1); end
      else begin order.push_back(1); order.push_back(0); end
    end else if (want_i) order.push_back(0);
    else if (want_d) order.push_back(1);
    bus.i_read = want_i; bus.i_address = ia;
    bus.d_read = want_d & d_rd; bus.d_write = want_d & d_wr;
    bus.d_address = da; bus.d_wdata = wd;
    pend_i = want_i; pend_d = want_d; prev_cmd = 0; wait_cnt = 0; cyc = 0; cur = -1; fired = '0;
    while ((pend_i || pend_d) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.mem_resp = 0;
      cmd = bus.mem_read | bus.mem_write;
      checks++; if (bus.mem_read && bus.mem_write) $display("FAIL cmd_exclusive read=%b write=%b expected not both", bus.mem_read, bus.mem_write); else passes++;
      checks++; if (bus.i_resp && bus.d_resp) $display("FAIL resp_exclusive i_resp=%b d_resp=%b expected not both", bus.i_resp, bus.d_resp); else passes++;
      if (cmd && !prev_cmd) begin
        cur = (order.size() > 0) ? order[0] : -1;
        wait_cnt = 0;
        if (cur == 0) begin
          checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) $display("FAIL i_cmd got r=%b w=%b expected r=1 w=0", bus.mem_read, bus.mem_write); else passes++;
          checks++; if (bus.mem_address !== ia) $display("FAIL i_addr got %h expected %h", bus.mem_address, ia); else passes++;
          bus.i_address = 12'($urandom);
        end else if (cur == 1) begin
          checks++; if (bus.mem_write !== d_wr || bus.mem_read !== !d_wr) $display("FAIL d_cmd got r=%b w=%b expected w=%b", bus.mem_read, bus.mem_write, d_wr); else passes++;
          checks++; if (bus.mem_address !== da) $display("FAIL d_addr got %h expected %h", bus.mem_address, da); else passes++;
          if (d_wr) begin
            checks++; if (bus.mem_wdata !== wd) $display("FAIL d_wdata got %h expected %h", bus.mem_wdata, wd); else passes++;
          end
          bus.d_address = 12'($urandom); bus.d_wdata = rand_line();
        end else begin
          checks++; $display("FAIL unexpected_cmd got r=%b w=%b expected none", bus.mem_read, bus.mem_write);
        end
      end
      if (cmd) begin
        if (wait_cnt == delay) begin
          checks++; if (bus.mem_address !== ((cur == 0) ? ia : da)) $display("FAIL addr_hold got %h expected %h", bus.mem_address, (cur == 0) ? ia : da); else passes++;
          fired = rand_line();
          bus.mem_rdata = fired;
          bus.mem_resp = 1;
        end
        wait_cnt++;
      end
      if (bus.i_resp || bus.d_resp) begin
        if (order.size() == 0) begin
          checks++; $display("FAIL spurious_resp i=%b d=%b expected none", bus.i_resp, bus.d_resp);
        end else begin
          checks++; if (int'(bus.d_resp) !== order[0]) $display("FAIL grant_order got d_resp=%b expected winner %0d", bus.d_resp, order[0]); else passes++;
          if (order[0] == 0) i_exp = fired;
          else if (!d_wr) d_exp = fired;
          checks++; if (bus.i_rdata !== i_exp) $display("FAIL i_rdata got %h expected %h", bus.i_rdata, i_exp); else passes++;
          checks++; if (bus.d_rdata !== d_exp) $display("FAIL d_rdata got %h expected %h", bus.d_rdata, d_exp); else passes++;
          if (order[0] == 0) begin pend_i = 0; bus.i_read = 0; end
          else begin pend_d = 0; bus.d_read = 0; bus.d_write = 0; end
          last_g = order.pop_front();
        end
      end
      prev_cmd = cmd;
    end
    if (pend_i || pend_d) begin
      checks++; $display("FAIL round_timeout pending i=%b d=%b expected both served", pend_i, pend_d);
      bus.i_read = 0; bus.d_read = 0; bus.d_write = 0;
    end
    bus.mem_resp = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if ({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp} !== 4'b0) $display("FAIL reset_ctrl got %b expected 0000", {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp}); else passes++;
    checks++; if (bus.mem_address !== 12'h0 || bus.mem_wdata !== '0) $display("FAIL reset_mem got %h/%h expected 0", bus.mem_address, bus.mem_wdata); else passes++;
    checks++; if (bus.i_rdata !== '0 || bus.d_rdata !== '0) $display("FAIL reset_rdata got %h/%h expected 0", bus.i_rdata, bus.d_rdata); else passes++;
  endtask

  task automatic test_i_read();
    logic [127:0] line;
    line = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
    apply_reset();
    bus.i_read = 1; bus.i_address = 12'h0A3;
    @(negedge clk);
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 12'h0A3) $display("FAIL iread_cmd got r=%b a=%h expected r=1 a=0a3", bus.mem_read, bus.mem_address); else passes++;
    repeat (2) @(negedge clk);
    bus.mem_resp = 1; bus.mem_rdata = line;
    @(negedge clk);
    bus.mem_resp = 0;
    checks++; if (bus.mem_read !== 1'b0) $display("FAIL iread_drop got %b expected 0", bus.mem_read); else passes++;
    checks++; if (bus.i_resp !== 1'b1 || bus.i_rdata !== line) $display("FAIL iread_resp got %b %h expected 1 %h", bus.i_resp, bus.i_rdata, line); else passes++;
    checks++; if (bus.d_resp !== 1'b0) $display("FAIL iread_dresp got %b expected 0", bus.d_resp); else passes++;
    bus.i_read = 0;
    @(negedge clk);
    checks++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) $display("FAIL iread_pulse got %b%b expected 00", bus.i_resp, bus.d_resp); else passes++;
  endtask

  task automatic test_d_write();
    apply_reset();
    do_round(0, 1, 1, 0, 12'h200, 12'h200, '0, 1);
    do_round(0, 1, 0, 1, 12'h000, 12'h010, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 2);
  endtask

  task automatic test_rw_both();
    do_round(0, 1, 1, 1, 12'h000, 12'h3F0, rand_line(), 0);
  endtask

  task automatic test_back_to_back();
    bit cmd, prev_cmd;
    int n, who[6], when[6];
    apply_reset();
    bus.i_read = 1; bus.i_address = 12'h111; bus.d_read = 1; bus.d_address = 12'h222;
    n = 0; prev_cmd = 0;
    for (int cyc = 0; cyc < 80 && n < 6; cyc++) begin
      @(negedge clk);
      cmd = bus.mem_read | bus.mem_write;
      // the bench memory answers one cycle after it first sees a command
      bus.mem_resp = cmd && prev_cmd;
      bus.mem_rdata = rand_line();
      if (bus.i_resp || bus.d_resp) begin who[n] = int'(bus.d_resp); when[n] = cyc; n++; end
      prev_cmd = cmd;
    end
    bus.i_read = 0; bus.d_read = 0; bus.mem_resp = 0;
    checks++; if (n != 6) $display("FAIL b2b_count got %0d expected 6", n); else passes++;
    for (int k = 0; k < n; k++) begin
      checks++; if (who[k] != ((k % 2 == 0) ? 1 : 0)) $display("FAIL b2b_order idx %0d got %0d expected %0d", k, who[k], (k % 2 == 0) ? 1 : 0); else passes++;
      if (k > 0) begin
        checks++; if (when[k] - when[k-1] != 4) $display("FAIL b2b_spacing idx %0d got %0d expected 4", k, when[k] - when[k-1]); else passes++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.i_read = 1; bus.i_address = 12'h055;
    @(negedge clk);
    checks++; if (bus.mem_read !== 1'b1) $display("FAIL mid_cmd got %b expected 1", bus.mem_read); else passes++;
    #2 rst_n = 0;
    #1;
    checks++; if (bus.mem_read !== 1'b0 || bus.mem_address !== 12'h0) $display("FAIL mid_async got r=%b a=%h expected 0 000", bus.mem_read, bus.mem_address); else passes++;
    bus.i_read = 0;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (bus.i_resp !== 1'b0 || bus.mem_read !== 1'b0) $display("FAIL mid_after got resp=%b r=%b expected 0 0", bus.i_resp, bus.mem_read); else passes++;
    end
  endtask

  task automatic test_spurious();
    apply_reset();
    bus.mem_resp = 1; bus.mem_rdata = rand_line();
    @(negedge clk);
    bus.mem_resp = 0;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({bus.i_resp, bus.d_resp, bus.mem_read, bus.mem_write} !== 4'b0 || bus.i_rdata !== '0) $display("FAIL spur_idle got %b rdata %h expected 0000 0", {bus.i_resp, bus.d_resp, bus.mem_read, bus.mem_write}, bus.i_rdata); else passes++;
      @(negedge clk);
    end
    bus.i_read = 1; bus.i_address = 12'h3C5;
    @(negedge clk);
    bus.i_address = 12'hFFF;
    @(negedge clk);
    checks++; if (bus.mem_address !== 12'h3C5 || bus.mem_read !== 1'b1) $display("FAIL spur_latch got a=%h r=%b expected 3c5 1", bus.mem_address, bus.mem_read); else passes++;
    bus.mem_resp = 1;
    @(negedge clk);
    bus.mem_resp = 0;
    checks++; if (bus.i_resp !== 1'b1) $display("FAIL spur_resp got %b expected 1", bus.i_resp); else passes++;
    bus.i_read = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit wi, wd, d_wr, d_rd;
    apply_reset();
    for (int r = 0; r < 24; r++) begin
      wi = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      if (!wi && !wd) wd = 1;
      d_wr = 1'($urandom_range(0, 1));
      d_rd = d_wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      do_round(wi, wd, d_rd, d_wr, 12'($urandom), 12'($urandom), rand_line(), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_rw_both();
    test_back_to_back();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
